// File: rtl/ha_bist.sv
// ha_bist: stimulus-and-check engine for a half-adder cell.
// Define HA_BIST_FAILLOG_EN to add capture of the first failing vector.
module ha_bist #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERRW   = 4
) (
  input  logic            m_clock,
  input  logic            p_reset_n,
  input  logic            start,
  output logic            dut_a,
  output logic            dut_b,
  input  logic            dut_s,
  input  logic            dut_c,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt,
  output logic            fail_valid,
  output logic [1:0]      fail_vec
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [1:0]      vec_q, vec_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            pass_q, pass_d, a_q, a_d, b_q, b_d;
  logic            accept, mism, last, run_d;
  assign accept = state_q == IDLE && start;
  // a_q/b_q hold the vector being checked, so they double as the reference inputs
  assign mism = state_q == CHECK && {dut_s, dut_c} != {a_q ^ b_q, a_q & b_q};
  assign last = vec_q == 2'd3 && pcnt_q == PW'(PASSES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT;
        cnt_d   = SW'(SETTLE - 1);
        vec_d   = '0;
        pcnt_d  = '0;
        err_d   = '0;
        pass_d  = 1'b0;
      end
      WAIT: begin
        state_d = cnt_q == '0 ? CHECK : WAIT;
        cnt_d   = cnt_q - SW'(1);
      end
      CHECK: begin
        err_d   = mism && err_q != '1 ? err_q + ERRW'(1) : err_q;
        state_d = last ? DONE : WAIT;
        pass_d  = last && err_d == '0;
        cnt_d   = SW'(SETTLE - 1);
        vec_d   = vec_q + 2'd1;
        pcnt_d  = vec_q == 2'd3 ? pcnt_q + PW'(1) : pcnt_q;
      end
      default: state_d = IDLE;
    endcase
    // Gray-ordered sweep: index 0..3 maps to {a,b} = 00,10,11,01
    run_d = state_d == WAIT || state_d == CHECK;
    a_d   = run_d && (vec_d[0] ^ vec_d[1]);
    b_d   = run_d && vec_d[1];
  end
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
  assign dut_a   = a_q;
  assign dut_b   = b_q;
  assign busy    = state_q == WAIT || state_q == CHECK;
  assign done    = state_q == DONE;
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef HA_BIST_FAILLOG_EN
  logic       fv_q;
  logic [1:0] fvec_q;
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      fv_q   <= 1'b0;
      fvec_q <= 2'b00;
    end else if (accept) begin
      fv_q   <= 1'b0;
      fvec_q <= 2'b00;
    end else if (mism && !fv_q) begin
      fv_q   <= 1'b1;
      fvec_q <= {a_q, b_q};
    end
  end
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = 2'b00;
`endif
endmodule

// File: tb/tb_ha_bist.sv
// tb_ha_bist: randomized self-check of ha_bist against a sweep-level reference model.
module tb_ha_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start0 = 1'b0, start1 = 1'b0, sel = 1'b0;
  logic [3:0] fs = 4'h0, fc = 4'h0;
  logic a0, b0, s0, c0, busy0, done0, pass0, fv0;
  logic a1, b1, s1, c1, busy1, done1, pass1, fv1;
  logic [3:0] e0, e1;
  logic [1:0] fvec0, fvec1;
  // faulty half-adder model: fs/fc flip s/c for the vector {a,b} they index
  assign s0 = (a0 ^ b0) ^ fs[{a0, b0}];
  assign c0 = (a0 & b0) ^ fc[{a0, b0}];
  assign s1 = (a1 ^ b1) ^ fs[{a1, b1}];
  assign c1 = (a1 & b1) ^ fc[{a1, b1}];
  ha_bist u0 (
    .m_clock(clk), .p_reset_n(rst_n), .start(start0), .dut_a(a0), .dut_b(b0),
    .dut_s(s0), .dut_c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(e0), .fail_valid(fv0), .fail_vec(fvec0)
  );
  ha_bist #(.SETTLE(1), .PASSES(8), .ERRW(4)) u1 (
    .m_clock(clk), .p_reset_n(rst_n), .start(start1), .dut_a(a1), .dut_b(b1),
    .dut_s(s1), .dut_c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(e1), .fail_valid(fv1), .fail_vec(fvec1)
  );
  logic o_a, o_b, o_busy, o_done, o_pass, o_fv;
  logic [3:0] o_err;
  logic [1:0] o_fvec;
  always_comb begin
    o_a    = sel ? a1 : a0;
    o_b    = sel ? b1 : b0;
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_pass = sel ? pass1 : pass0;
    o_fv   = sel ? fv1 : fv0;
    o_err  = sel ? e1 : e0;
    o_fvec = sel ? fvec1 : fvec0;
  end
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive_start(input logic v);
    if (sel) start1 = v;
    else start0 = v;
  endtask
  // gmode: 0 no re-pulse, 1 re-pulse on cycles 3 and 8, 2 random start noise during the run
  task automatic run(input logic who, input logic [3:0] f_s, input logic [3:0] f_c,
                     input int gmode, input string tag);
    int st, np, n, run_err, total, exp_fin, bad_bb, bad_v, bad_e, bad_p;
    logic [1:0] v, first_v;
    logic first_ok;
    logic [1:0] order [4];
    order = '{2'b00, 2'b10, 2'b11, 2'b01};
    st = who ? 1 : 2;
    np = who ? 8 : 1;
    n = 4 * np * (st + 1);
    total = 0;
    first_ok = 1'b0;
    first_v = 2'b00;
    for (int p = 0; p < np; p++)
      for (int i = 0; i < 4; i++)
        if (f_s[order[i]] | f_c[order[i]]) begin
          total++;
          if (!first_ok) begin
            first_ok = 1'b1;
            first_v = order[i];
          end
        end
    exp_fin = total > 15 ? 15 : total;
    sel = who;
    fs = f_s;
    fc = f_c;
    drive_start(1'b1);
    run_err = 0;
    bad_bb = 0; bad_v = 0; bad_e = 0; bad_p = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      v = order[((k - 1) / (st + 1)) % 4];
      if (o_busy !== 1'b1 || o_done !== 1'b0) bad_bb++;
      if ({o_a, o_b} !== v) bad_v++;
      if (o_err !== 4'(run_err)) bad_e++;
      if (o_pass !== 1'b0) bad_p++;
      if (k % (st + 1) == 0 && (f_s[v] | f_c[v]) && run_err < 15) run_err++;
      drive_start(gmode == 1 ? (k == 3 || k == 8) :
                  gmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    @(negedge clk);
    drive_start(1'b0);
    chk({tag, ":busy_window"}, bad_bb, 0);
    chk({tag, ":vector_seq"}, bad_v, 0);
    chk({tag, ":err_running"}, bad_e, 0);
    chk({tag, ":pass_cleared"}, bad_p, 0);
    chk({tag, ":done_cycle"}, {o_busy, o_done, o_a, o_b}, 4'b0100);
    chk({tag, ":pass"}, o_pass, exp_fin == 0);
    chk({tag, ":err_cnt"}, o_err, exp_fin);
`ifdef HA_BIST_FAILLOG_EN
    chk({tag, ":fail_log"}, {o_fv, o_fvec}, {first_ok, first_v});
`else
    chk({tag, ":fail_log"}, {o_fv, o_fvec}, 3'b000);
`endif
    @(negedge clk);
    chk({tag, ":idle_after"}, {o_busy, o_done, o_pass, o_err}, {3'b001 & {2'b00, 1'(exp_fin == 0)}, 4'(exp_fin)});
  endtask
  initial begin
    int bad;
    #2;
    chk("reset_u0", {busy0, done0, pass0, e0, a0, b0, fv0, fvec0}, 0);
    chk("reset_u1", {busy1, done1, pass1, e1, a1, b1, fv1, fvec1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 4'h0, 4'h0, 0, "clean");
    run(1'b0, 4'h0, 4'b1000, 0, "c_stuck0");
    run(1'b0, 4'hF, 4'h0, 0, "s_inv");
    run(1'b1, 4'hF, 4'h0, 0, "sat8");
    sel = 1'b0;
    fs = 4'h0;
    fc = 4'h0;
    drive_start(1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive_start(1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy0, done0, pass0, e0, a0, b0, fv0, fvec0}, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    chk("abort_no_done", bad, 0);
    rst_n = 1'b1;
    run(1'b0, 4'h0, 4'h0, 0, "after_rst");
    run(1'b0, 4'b0110, 4'h0, 1, "repulse");
    run(1'b1, 4'h0, 4'h0, 0, "clean8");
    for (int r = 0; r < 6; r++)
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2, "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
